risc_wb_arbiter: RTL and testbench

- Arbitrates the single register-file write port (RW, DA, D_Data) between two writeback sources: source A (ALU result path) and source B (load/memory return path).
- Uses a valid/ready handshake per source and round-robin priority on contention.
- Registers the winning write, then drives the register file write inputs one cycle later.
- Sits between the execute/memory stages and RISC_reg_file; also filters writes to r0.

---
 rtl/risc_wb_arbiter.sv | 109 ++++++++++
 tb/tb_risc_wb_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/risc_wb_arbiter.sv
// rtl/risc_wb_arbiter.sv - round-robin writeback arbiter for the register-file write port
// Optional statistics counters: define RISC_WB_STATS_EN.
module risc_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_da,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_da,
  input  logic [DATA_W-1:0] b_data,
  input  logic              wb_hold,
  output logic              RW,
  output logic [ADDR_W-1:0] DA,
  output logic [DATA_W-1:0] D_Data,
  output logic              last_grant
`ifdef RISC_WB_STATS_EN
  ,
  output logic [15:0]       grant_cnt_a,
  output logic [15:0]       grant_cnt_b,
  output logic [15:0]       conflict_cnt
`endif
);

  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] da_q, da_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              last_q, last_d;
  logic              grant_a, grant_b;

  // On contention the source that did not win last time goes next.
  assign grant_a = !wb_hold && a_valid && (!b_valid || last_q);
  assign grant_b = !wb_hold && b_valid && (!a_valid || !last_q);
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  always_comb begin
    rw_d   = 1'b0;
    da_d   = da_q;
    data_d = data_q;
    last_d = last_q;
    if (grant_a) begin
      rw_d   = (a_da != '0);
      da_d   = a_da;
      data_d = a_data;
      last_d = 1'b0;
    end else if (grant_b) begin
      rw_d   = (b_da != '0);
      da_d   = b_da;
      data_d = b_data;
      last_d = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      rw_q   <= 1'b0;
      da_q   <= '0;
      data_q <= '0;
      last_q <= 1'b1;
    end else begin
      rw_q   <= rw_d;
      da_q   <= da_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign RW         = rw_q;
  assign DA         = da_q;
  assign D_Data     = data_q;
  assign last_grant = last_q;

`ifdef RISC_WB_STATS_EN
  logic [15:0] cnt_a_q, cnt_b_q, cnt_c_q;
  logic [15:0] cnt_a_d, cnt_b_d, cnt_c_d;

  always_comb begin
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    cnt_c_d = cnt_c_q;
    if (grant_a && cnt_a_q != 16'hFFFF) cnt_a_d = cnt_a_q + 16'd1;
    if (grant_b && cnt_b_q != 16'hFFFF) cnt_b_d = cnt_b_q + 16'd1;
    if (!wb_hold && a_valid && b_valid && cnt_c_q != 16'hFFFF) cnt_c_d = cnt_c_q + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_c_q <= '0;
    end else begin
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_c_q <= cnt_c_d;
    end
  end

  assign grant_cnt_a  = cnt_a_q;
  assign grant_cnt_b  = cnt_b_q;
  assign conflict_cnt = cnt_c_q;
`endif

endmodule

// File: tb/tb_risc_wb_arbiter.sv
// tb/tb_risc_wb_arbiter.sv - directed table plus randomized model check of risc_wb_arbiter
module tb_risc_wb_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          CLK = 1'b0;
  logic          reset, a_valid, b_valid, wb_hold;
  logic [AW-1:0] a_da, b_da;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready, RW, last_grant;
  logic [AW-1:0] DA;
  logic [DW-1:0] D_Data;
`ifdef RISC_WB_STATS_EN
  logic [15:0]   grant_cnt_a, grant_cnt_b, conflict_cnt;
`endif

  always #5 CLK = ~CLK;

  risc_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_da(a_da), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_da(b_da), .b_data(b_data),
    .wb_hold(wb_hold), .RW(RW), .DA(DA), .D_Data(D_Data), .last_grant(last_grant)
`ifdef RISC_WB_STATS_EN
    , .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b), .conflict_cnt(conflict_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: what the register-file port should show after the last edge.
  bit            m_last;
  bit            m_rw;
  logic [AW-1:0] m_da;
  logic [DW-1:0] m_data;
  int            m_ca, m_cb, m_cc;

  typedef struct {
    bit            rst;
    bit            av;
    logic [AW-1:0] ada;
    logic [DW-1:0] ad;
    bit            bv;
    logic [AW-1:0] bda;
    logic [DW-1:0] bd;
    bit            hold;
    bit            e_ar;
    bit            e_br;
    bit            e_rw;
    logic [AW-1:0] e_da;
    logic [DW-1:0] e_dat;
    bit            e_last;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = nobody, 1 = A, 2 = B
  function automatic int winner(bit av, bit bv, bit hold, bit last);
    if (hold || !(av || bv)) return 0;
    if (av && bv) return last ? 1 : 2;
    return av ? 1 : 2;
  endfunction

  function automatic int sat_inc(int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic cycle(input bit rst, input bit av, input logic [AW-1:0] ada, input logic [DW-1:0] ad,
                       input bit bv, input logic [AW-1:0] bda, input logic [DW-1:0] bd, input bit hold,
                       output bit gar, output bit gbr);
    int w;
    reset = rst; a_valid = av; a_da = ada; a_data = ad;
    b_valid = bv; b_da = bda; b_data = bd; wb_hold = hold;
    @(negedge CLK);
    w   = winner(av, bv, hold, m_last);
    gar = a_ready;
    gbr = b_ready;
    check("a_ready", a_ready, w == 1);
    check("b_ready", b_ready, w == 2);
    @(posedge CLK);
    if (rst) begin
      m_rw = 0; m_da = '0; m_data = '0; m_last = 1;
      m_ca = 0; m_cb = 0; m_cc = 0;
    end else begin
      if (!hold && av && bv) m_cc = sat_inc(m_cc);
      if (w == 1) begin
        m_rw = (ada != 0); m_da = ada; m_data = ad; m_last = 0; m_ca = sat_inc(m_ca);
      end else if (w == 2) begin
        m_rw = (bda != 0); m_da = bda; m_data = bd; m_last = 1; m_cb = sat_inc(m_cb);
      end else begin
        m_rw = 0;
      end
    end
    #1;
    check("RW", RW, m_rw);
    check("DA", DA, m_da);
    check("D_Data", D_Data, m_data);
    check("last_grant", last_grant, m_last);
`ifdef RISC_WB_STATS_EN
    check("grant_cnt_a", grant_cnt_a, m_ca[15:0]);
    check("grant_cnt_b", grant_cnt_b, m_cb[15:0]);
    check("conflict_cnt", conflict_cnt, m_cc[15:0]);
`endif
  endtask

  initial begin
    bit            gar, gbr;
    bit            pa, pb;
    logic [AW-1:0] rada, rbda;
    logic [DW-1:0] rad, rbd;

    //        rst av ada ad            bv bda bd          hold ar br rw da dat           last
    tbl[0]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,       0,   0, 0, 0, 0, 32'h0,        1};
    tbl[1]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,       0,   0, 0, 0, 0, 32'h0,        1};
    tbl[2]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,       0,   1, 0, 1, 5, 32'hDEADBEEF, 0};
    tbl[3]  = '{0, 0, 0, 32'h0,        0, 0, 32'h0,       0,   0, 0, 0, 5, 32'hDEADBEEF, 0};
    tbl[4]  = '{1, 0, 0, 32'h0,        0, 0, 32'h0,       0,   0, 0, 0, 0, 32'h0,        1};
    tbl[5]  = '{0, 1, 3, 32'h1,        1, 4, 32'h2,       0,   1, 0, 1, 3, 32'h1,        0};
    tbl[6]  = '{0, 1, 3, 32'h1,        1, 4, 32'h2,       0,   0, 1, 1, 4, 32'h2,        1};
    tbl[7]  = '{0, 1, 3, 32'h1,        1, 4, 32'h2,       0,   1, 0, 1, 3, 32'h1,        0};
    tbl[8]  = '{0, 1, 3, 32'h1,        1, 4, 32'h2,       0,   0, 1, 1, 4, 32'h2,        1};
    tbl[9]  = '{0, 0, 0, 32'h0,        1, 0, 32'h1234,    0,   0, 1, 0, 0, 32'h1234,     1};
    tbl[10] = '{0, 1, 3, 32'h1,        1, 4, 32'h2,       0,   1, 0, 1, 3, 32'h1,        0};
    tbl[11] = '{0, 1, 3, 32'h1,        1, 4, 32'h2,       1,   0, 0, 0, 3, 32'h1,        0};
    tbl[12] = '{0, 1, 3, 32'h1,        1, 4, 32'h2,       1,   0, 0, 0, 3, 32'h1,        0};
    tbl[13] = '{0, 1, 3, 32'h1,        1, 4, 32'h2,       1,   0, 0, 0, 3, 32'h1,        0};
    tbl[14] = '{0, 1, 3, 32'h1,        1, 4, 32'h2,       0,   0, 1, 1, 4, 32'h2,        1};
    tbl[15] = '{0, 1, 7, 32'h77,       0, 0, 32'h0,       0,   1, 0, 1, 7, 32'h77,       0};
    tbl[16] = '{1, 1, 7, 32'h77,       0, 0, 32'h0,       0,   1, 0, 0, 0, 32'h0,        1};
    tbl[17] = '{0, 0, 0, 32'h0,        0, 0, 32'h0,       0,   0, 0, 0, 0, 32'h0,        1};

    reset = 1; a_valid = 0; b_valid = 0; wb_hold = 0;
    a_da = '0; b_da = '0; a_data = '0; b_data = '0;
    repeat (2) @(posedge CLK);
    #1;
    m_last = 1; m_rw = 0; m_da = '0; m_data = '0; m_ca = 0; m_cb = 0; m_cc = 0;

    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].rst, tbl[i].av, tbl[i].ada, tbl[i].ad, tbl[i].bv, tbl[i].bda, tbl[i].bd,
            tbl[i].hold, gar, gbr);
      check($sformatf("tbl%0d a_ready", i), gar, tbl[i].e_ar);
      check($sformatf("tbl%0d b_ready", i), gbr, tbl[i].e_br);
      check($sformatf("tbl%0d RW", i), RW, tbl[i].e_rw);
      check($sformatf("tbl%0d DA", i), DA, tbl[i].e_da);
      check($sformatf("tbl%0d D_Data", i), D_Data, tbl[i].e_dat);
      check($sformatf("tbl%0d last_grant", i), last_grant, tbl[i].e_last);
    end

    // Sources keep a write presented until it is accepted.
    pa = 0; pb = 0;
    rada = '0; rbda = '0; rad = '0; rbd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!pa && ($urandom_range(0, 3) != 0)) begin
        pa = 1; rada = AW'($urandom_range(0, 31)); rad = $urandom;
        if ($urandom_range(0, 5) == 0) rada = '0;
      end
      if (!pb && ($urandom_range(0, 3) != 0)) begin
        pb = 1; rbda = AW'($urandom_range(0, 31)); rbd = $urandom;
        if ($urandom_range(0, 5) == 0) rbda = '0;
      end
      cycle($urandom_range(0, 63) == 0, pa, rada, rad, pb, rbda, rbd,
            $urandom_range(0, 7) == 0, gar, gbr);
      if (gar) pa = 0;
      if (gbr) pb = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
